bus_arbiter_rr: RTL

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_arbiter_rr_if.sv | 30 +++
 rtl/rr_priority_picker.sv | 29 ++
 rtl/bus_arbiter_rr.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter with split-transaction support.
package bus_arb_pkg;

    localparam int ARB_MAX_INIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_OWNED        = 2'd1,
        ST_SPLIT_RETURN = 2'd2
    } arb_state_t;

    function automatic logic [ARB_MAX_INIT-1:0] idx_to_onehot(input logic [2:0] idx);
        return ARB_MAX_INIT'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bus-side signal bundle of the arbiter: initiator requests, target pulses and the grant outputs.
interface bus_arbiter_rr_if #(
    parameter int NUM_INIT = 2
);
    localparam int IDX_W = $clog2(NUM_INIT);

    // init_req and split_req are levels held until served; txn_done and split_ack are
    // one-cycle target pulses that only act while a grant is live; grants are registered.
    logic [NUM_INIT-1:0] init_req;
    logic [NUM_INIT-1:0] init_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic                txn_done;
    logic                split_ack;
    logic                split_req;
    logic                split_grant;
    logic                split_pending;
    logic                timeout_err;

    modport master (
        output init_req, txn_done, split_ack, split_req,
        input  init_grant, grant_idx, grant_valid, split_grant, split_pending, timeout_err
    );

    modport slave (
        input  init_req, txn_done, split_ack, split_req,
        output init_grant, grant_idx, grant_valid, split_grant, split_pending, timeout_err
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request starting one above the pointer, wrapping.
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);
    int                 pos;
    logic [NUM_REQ-1:0] shifted;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        shifted = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos     = (int'(ptr_i) + k) % NUM_REQ;
            shifted = req_i >> pos;
            if (!found_o && shifted[0]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with one outstanding split transaction.
// Optional ownership watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT       = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_arbiter_rr_if.slave bus,
    output arb_state_t      state_o
);
    localparam int IDX_W = $clog2(NUM_INIT);

    if (NUM_INIT < 2 || NUM_INIT > ARB_MAX_INIT || TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("bus_arbiter_rr: parameter out of range");
    end

    arb_state_t          state_q, state_d;
    logic [NUM_INIT-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_winner_q, last_winner_d;
    logic [IDX_W-1:0]    split_owner_q, split_owner_d;
    logic                split_grant_q, split_grant_d;
    logic                split_pending_q, split_pending_d;
    logic                timeout_err_q, timeout_err_d;

    logic                decide;
    logic                timeout_hit;
    logic                split_take;
    logic                mask_en;
    logic [IDX_W-1:0]    mask_idx;
    logic [NUM_INIT-1:0] eligible;
    logic [IDX_W-1:0]    winner;
    logic                found;

    // The split owner is masked both while the split is outstanding and on the very
    // edge the split_ack arrives, so it cannot be re-granted its own deferred slot.
    assign split_take = (state_q == ST_OWNED) && bus.split_ack && !split_pending_q;
    assign mask_en    = split_take || (split_pending_q && (state_q != ST_SPLIT_RETURN));
    assign mask_idx   = split_take ? idx_q : split_owner_q;
    assign eligible   = bus.init_req & ~(mask_en ? NUM_INIT'(idx_to_onehot(3'(mask_idx))) : '0);

    rr_priority_picker #(
        .NUM_REQ (NUM_INIT),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (eligible),
        .ptr_i   (last_winner_q),
        .idx_o   (winner),
        .found_o (found)
    );

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        idx_d           = idx_q;
        last_winner_d   = last_winner_q;
        split_owner_d   = split_owner_q;
        split_grant_d   = split_grant_q;
        split_pending_d = split_pending_q;
        timeout_err_d   = 1'b0;
        decide          = 1'b0;

        case (state_q)
            ST_OWNED: begin
                if (split_take) begin
                    split_pending_d = 1'b1;
                    split_owner_d   = idx_q;
                end
                decide        = split_take | bus.txn_done | ~bus.init_req[idx_q] | timeout_hit;
                timeout_err_d = timeout_hit;
            end
            ST_SPLIT_RETURN: begin
                if (bus.txn_done || timeout_hit) begin
                    split_pending_d = 1'b0;
                    decide          = 1'b1;
                end
                timeout_err_d = timeout_hit;
            end
            default: decide = 1'b1;
        endcase

        if (decide) begin
            if (split_pending_q && split_pending_d && bus.split_req) begin
                // Return phase keeps last_winner so the rotation is not disturbed.
                state_d       = ST_SPLIT_RETURN;
                grant_d       = NUM_INIT'(idx_to_onehot(3'(split_owner_q)));
                idx_d         = split_owner_q;
                split_grant_d = 1'b1;
            end else if (found) begin
                state_d       = ST_OWNED;
                grant_d       = NUM_INIT'(idx_to_onehot(3'(winner)));
                idx_d         = winner;
                last_winner_d = winner;
                split_grant_d = 1'b0;
            end else begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                split_grant_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            idx_q           <= '0;
            last_winner_q   <= IDX_W'(NUM_INIT - 1);
            split_owner_q   <= '0;
            split_grant_q   <= 1'b0;
            split_pending_q <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            idx_q           <= idx_d;
            last_winner_q   <= last_winner_d;
            split_owner_q   <= split_owner_d;
            split_grant_q   <= split_grant_d;
            split_pending_q <= split_pending_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    // Every grant decision starts a fresh ownership, so the count restarts there.
    assign wd_d        = decide ? 16'd0 : wd_q + 16'd1;
    assign timeout_hit = (state_q != ST_IDLE) && (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus.init_grant    = grant_q;
    assign bus.grant_idx     = idx_q;
    assign bus.grant_valid   = |grant_q;
    assign bus.split_grant   = split_grant_q;
    assign bus.split_pending = split_pending_q;
    assign bus.timeout_err   = timeout_err_q;
    assign state_o           = state_q;

endmodule
